// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin arbiter that shares one holding register among N_REQ
//   requesters, such as MAC lanes writing partial sums toward writeback.
//   The winning requester's word is captured into the register and offered
//   downstream with a valid/ready handshake. The register behaves as a
//   one-deep pipeline buffer that can drain and refill in the same cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset; all state clears while low
//   req       per-requester request, held high until the matching gnt
//   req_data  flat data bus, requester i at bits [i*DW +: DW]
//   gnt       one-hot combinational grant (forced to 0 while rst is low)
//   y_data    holding register contents
//   y_src     index of the requester whose word is in y_data
//   y_valid   y_data holds an unconsumed word
//   y_ready   downstream accepts y_data this cycle when y_valid is high
//   busy_cnt  saturating count of cycles with a request pending but no grant
//
// IW must equal clog2(N_REQ).
module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int IW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       y_data,
  output logic [IW-1:0]       y_src,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [7:0]          busy_cnt
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          found;
  logic          can_load;
  logic          grant_any;
  logic [IW-1:0] next_ptr;

  // The register can take a new word when it is empty or when its current
  // word leaves this same cycle; this is what permits 1 word/cycle.
  assign can_load = ~y_valid | y_ready;

  // Search requests starting at rr_ptr, ascending with wrap-around.
  // The first set bit found is the winner.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Including rst here keeps gnt low for the whole reset period, so no
  // requester believes its word was taken while the register is held clear.
  assign grant_any = found & can_load & rst;

  always_comb begin
    gnt = '0;
    if (grant_any) begin
      gnt[win] = 1'b1;
    end
  end

  // Pointer moves just past the winner so a continuously requesting
  // neighbour is always served before the same requester wins again.
  always_comb begin
    next_ptr = win + IW'(1);
    if (win == IW'(N_REQ - 1)) begin
      next_ptr = '0;
    end
  end

  // Holding register, source tag and round-robin pointer. A grant always
  // reloads; a drain with no grant only clears valid and leaves the old
  // word visible. A full stall leaves everything untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_data  <= '0;
      y_src   <= '0;
      y_valid <= 1'b0;
      rr_ptr  <= '0;
    end else if (grant_any) begin
      y_data  <= req_data[int'(win)*DW +: DW];
      y_src   <= win;
      y_valid <= 1'b1;
      rr_ptr  <= next_ptr;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Stall counter: counts edges where someone is waiting but nobody was
  // granted. Sticks at 255 and only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
    end else if ((|req) && !grant_any && (busy_cnt != 8'hFF)) begin
      busy_cnt <= busy_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
//   Directed bench for reg_share_arbiter (N_REQ=4, DW=32, IW=2).
//   Inputs change 1ns after a rising edge; outputs are checked 1ns later,
//   well away from the next active edge.
module tb_reg_share_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 32;
  localparam int IW    = 2;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       y_data;
  logic [IW-1:0]       y_src;
  logic                y_valid;
  logic                y_ready;
  logic [7:0]          busy_cnt;

  int checks;
  int failures;

  reg_share_arbiter #(.N_REQ(N_REQ), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .y_data   (y_data),
    .y_src    (y_src),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .busy_cnt (busy_cnt)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against the bench's expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive request vector and downstream ready, then let logic settle.
  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic rdy);
    req     = r;
    y_ready = rdy;
    #1;
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    req      = '0;
    y_ready  = 1'b0;
    req_data = '0;

    // ---------------- reset state
    step();
    step();
    checkOutput("reset_y_valid", 64'(y_valid), 64'd0);
    checkOutput("reset_y_data", 64'(y_data), 64'd0);
    checkOutput("reset_y_src", 64'(y_src), 64'd0);
    checkOutput("reset_busy", 64'(busy_cnt), 64'd0);
    checkOutput("reset_gnt", 64'(gnt), 64'd0);
    rst = 1'b1;
    step();

    // ---------------- single requester, consecutive grants
    setData(2, 32'hDEADBEEF);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_gnt0", 64'(gnt), 64'h4);
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("single_gnt", 64'(gnt), 64'h4);
      checkOutput("single_y_data", 64'(y_data), 64'hDEADBEEF);
      checkOutput("single_y_valid", 64'(y_valid), 64'd1);
      checkOutput("single_y_src", 64'(y_src), 64'd2);
    end
    // rr_ptr is now 3; drain with no requests
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drain_gnt", 64'(gnt), 64'h0);
    step();
    checkOutput("drain_y_valid", 64'(y_valid), 64'd0);
    checkOutput("drain_y_data_hold", 64'(y_data), 64'hDEADBEEF);
    checkOutput("drain_y_src_hold", 64'(y_src), 64'd2);

    // ---------------- wrap and skip from rr_ptr=3
    setData(0, 32'hA0A0A0A0);
    setData(2, 32'hA2A2A2A2);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("wrap_gnt0", 64'(gnt), 64'h1);
    step();
    checkOutput("wrap_y_src0", 64'(y_src), 64'd0);
    checkOutput("wrap_y_data0", 64'(y_data), 64'hA0A0A0A0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("wrap_gnt2", 64'(gnt), 64'h4);
    step();
    checkOutput("wrap_y_src2", 64'(y_src), 64'd2);
    checkOutput("wrap_y_data2", 64'(y_data), 64'hA2A2A2A2);
    // rr_ptr=3: grant requester 3 alone to bring the pointer back to 0
    setData(3, 32'h33333333);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("ptr_gnt3", 64'(gnt), 64'h8);
    step();
    checkOutput("ptr_y_src3", 64'(y_src), 64'd3);

    // ---------------- round robin, all requesting, rr_ptr=0
    for (int i = 0; i < N_REQ; i++) setData(i, 32'h10000000 + 32'(i));
    applyStimulus(4'b1111, 1'b1);
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int c = 0; c < 5; c++) begin
        checkOutput("rr_gnt", 64'(gnt), 64'(4'b0001 << order[c]));
        step();
        checkOutput("rr_y_src", 64'(y_src), 64'(order[c]));
        checkOutput("rr_y_data", 64'(y_data), 64'(32'h10000000 + 32'(order[c])));
      end
    end
    checkOutput("rr_busy_zero", 64'(busy_cnt), 64'd0);

    // ---------------- backpressure, rr_ptr=1, holding word from requester 0
    applyStimulus(4'b0011, 1'b0);
    checkOutput("bp_gnt_start", 64'(gnt), 64'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("bp_gnt", 64'(gnt), 64'h0);
      checkOutput("bp_y_data", 64'(y_data), 64'h10000000);
      checkOutput("bp_y_valid", 64'(y_valid), 64'd1);
    end
    checkOutput("bp_busy5", 64'(busy_cnt), 64'd5);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("bp_release_gnt", 64'(gnt), 64'h2);
    step();
    checkOutput("bp_release_y_src", 64'(y_src), 64'd1);
    checkOutput("bp_release_y_data", 64'(y_data), 64'h10000001);
    checkOutput("bp_release_busy", 64'(busy_cnt), 64'd5);

    // ---------------- saturation: 300 stall cycles starting from 5
    applyStimulus(4'b0011, 1'b0);
    repeat (249) step();
    checkOutput("sat_254", 64'(busy_cnt), 64'd254);
    step();
    checkOutput("sat_255", 64'(busy_cnt), 64'd255);
    repeat (50) step();
    checkOutput("sat_hold", 64'(busy_cnt), 64'd255);
    checkOutput("sat_y_valid", 64'(y_valid), 64'd1);

    // ---------------- asynchronous reset mid-transfer
    applyStimulus(4'b0010, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("arst_y_data", 64'(y_data), 64'd0);
    checkOutput("arst_y_valid", 64'(y_valid), 64'd0);
    checkOutput("arst_gnt", 64'(gnt), 64'h0);
    checkOutput("arst_busy", 64'(busy_cnt), 64'd0);
    step();
    rst = 1'b1;
    #1;
    checkOutput("post_rst_gnt", 64'(gnt), 64'h2);
    step();
    checkOutput("post_rst_y_src", 64'(y_src), 64'd1);
    checkOutput("post_rst_y_valid", 64'(y_valid), 64'd1);
    checkOutput("post_rst_y_data", 64'(y_data), 64'h10000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
